bch_scoreboard: RTL and testbench
=================================

# bch_scoreboard

Synthesizable, parametrised self-check scoreboard for the BCH encode → syndrome → key-solver → error-locator chain. It records the injected error pattern for every codeword entering the encoder. It then checks three points in order against that record: the errors-present flag, the solver error count, and the reassembled error vector. It reports sticky failure causes, saturating mismatch counters and a first-failure snapshot. It is used on-chip in BIST builds and in the regression benches, replacing ad-hoc per-bench checking logic.

## Interface
Parameters:
- P, `BCH_SANE, BCH parameter vector; B = `BCH_DATA_BITS(P), ES = `BCH_ERR_SZ(P)
- BITS, 1, error-locator output width per beat; B % BITS must be 0, otherwise elaboration fails
- DEPTH, 16, expected-entry store depth; power of two, ≥ 2
- CNT_W, 16, width of each mismatch/check counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset
- push  in  1  record a new expected entry (one per codeword accepted by encoder)
- push_err  in  B  injected error pattern for that codeword
- push_ready  out  1  store not full
- pres_valid  in  1  errors-present result strobe
- pres_actual  in  1  errors-present result
- count_valid  in  1  solver err_count strobe
- count_actual  in  ES  solver err_count
- err_valid  in  1  locator beat valid
- err_first  in  1  first beat of vector (qualified by err_valid)
- err_last  in  1  last beat of vector (qualified by err_valid)
- err  in  BITS  locator beat; first beat = lowest bits
- wrong  out  1  sticky: any failure since reset/clear
- fail_cause  out  5  sticky {underflow, overflow, vector, count, present}
- pres_mis, count_mis, vec_mis  out  CNT_W  saturating mismatch counts
- checked  out  CNT_W  saturating count of completed vector checks
- first_fail_idx  out  CNT_W  value of `checked` at the first failure
- level  out  log2(DEPTH)+1  entries not yet vector-checked

## Operation
- Store: DEPTH entries of {pattern B, popcount ES, |pattern}. Popcount and OR are computed at push time.
- One write pointer. Three read pointers: rp_pres, rp_cnt, rp_vec. Each advances independently modulo DEPTH.
- Full when (wp+1)%DEPTH equals any read pointer, so DEPTH-1 entries are usable. push_ready = !full.
- push while full: entry dropped, wp unchanged, overflow set.
- pres_valid: compare pres_actual against the entry at rp_pres, then advance rp_pres. count_valid works the same way with rp_cnt.
- Strobe arriving while its pointer equals wp (empty): underflow set, no compare, pointer held.
- Vector reassembly:
  - On err_valid&err_first: buf = err << (B-BITS).
  - On other err_valid beats: buf = (err << (B-BITS)) | (buf >> BITS).
  - When BITS == B, first and last coincide.
- err_valid&err_last: sets vec_done for one cycle. During vec_done, buf is compared with the entry at rp_vec, rp_vec advances and checked increments.
- Any mismatch: sets the cause bit and increments its counter (saturating at all-ones).
- On the first failure of any cause: wrong rises and first_fail_idx latches the current `checked` value.
- Reset/clear: all pointers, counters, causes and buffer are zeroed.

## Timing
- Reset values: wrong=0, fail_cause=0, all counters 0, first_fail_idx=0, level=0, push_ready=1.
- All outputs are registered. wrong and fail_cause update 1 cycle after the offending strobe.
- Vector mismatch: reported 2 cycles after the err_last beat (vec_done stage, then flag register).
- Push at cycle t is readable by a strobe at t+1. A strobe in the same cycle as the push sees the store as empty.
- Simultaneous push and vector-check in a full store: the check frees its slot only at the next edge, so the push is still rejected (overflow).
- Several causes in one cycle: all bits set. first_fail_idx is captured once.
- clear has priority over all strobes in the same cycle.
- reset asserted mid-vector discards the partial buf.

## Structure
- Shared package/header (bch_defs.vh): a localparam for fail_cause bit positions, and a log2 helper reused from bch.vh.
- One sub-module: bch_scoreboard_popcount (combinational B-bit popcount → ES). It is shared with other benches.

## Test plan
- DEPTH=4, BITS=1. Push 3 patterns (0, bit0|bit5, bit2), then feed matching pres/count/vector streams → wrong=0, checked=3, level=0.
- Push bit0|bit5, drive count_actual=1 → 1 cycle later fail_cause=00010, count_mis=1, wrong=1, first_fail_idx=0.
- Push 4 entries into DEPTH=4 → 4th push gives push_ready=0 and overflow set; level=3.
- pres_valid with an empty store → underflow set, rp_pres unchanged, pres_mis=0.
- BITS=B: single beat with err_first=err_last=1 carrying pattern^bit3 → vec_mis=1, reported 2 cycles later.
- Force the count mismatch 2^CNT_W+5 times with CNT_W=4 → count_mis=15. Then assert clear → all outputs back to reset values; no cycle shows a partial clear.

Source files
------------

// File: rtl/bch_scoreboard_pkg.sv
// Shared definitions for the BCH self-check scoreboard: fail_cause bit
// positions and a ceil-log2 helper for elaboration-time sizing.
package bch_scoreboard_pkg;

    localparam int CAUSE_W    = 5;
    localparam int CAUSE_PRES = 0;
    localparam int CAUSE_CNT  = 1;
    localparam int CAUSE_VEC  = 2;
    localparam int CAUSE_OVF  = 3;
    localparam int CAUSE_UNF  = 4;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bch_scoreboard_popcount.sv
// Combinational population count of a DATA_W-bit word into ES bits.
module bch_scoreboard_popcount #(
    parameter int DATA_W = 16,
    parameter int ES     = 5
) (
    input  logic [DATA_W-1:0] data,
    output logic [ES-1:0]     count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DATA_W; i++) begin
            count = count + ES'(data[i]);
        end
    end

endmodule

// File: rtl/bch_scoreboard.sv
// Self-check scoreboard for the BCH encode/syndrome/solver/locator chain:
// records injected error patterns and checks present flag, count and vector.
module bch_scoreboard
    import bch_scoreboard_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BITS   = 1,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int ES    = log2c(DATA_W + 1),
    localparam int AW    = log2c(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_err,
    output logic               push_ready,
    input  logic               pres_valid,
    input  logic               pres_actual,
    input  logic               count_valid,
    input  logic [ES-1:0]      count_actual,
    input  logic               err_valid,
    input  logic               err_first,
    input  logic               err_last,
    input  logic [BITS-1:0]    err,
    output logic               wrong,
    output logic [CAUSE_W-1:0] fail_cause,
    output logic [CNT_W-1:0]   pres_mis,
    output logic [CNT_W-1:0]   count_mis,
    output logic [CNT_W-1:0]   vec_mis,
    output logic [CNT_W-1:0]   checked,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [AW:0]        level
);

    if ((DATA_W % BITS) != 0) begin : g_bits_chk
        $error("bch_scoreboard: DATA_W must be a multiple of BITS");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("bch_scoreboard: DEPTH must be a power of two >= 2");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0]  pat_mem [DEPTH];
    logic [ES-1:0]      pop_mem [DEPTH];
    logic               any_mem [DEPTH];

    logic [AW-1:0]      wp_q, wp_d, rp_pres_q, rp_pres_d, rp_cnt_q, rp_cnt_d, rp_vec_q, rp_vec_d;
    logic [DATA_W-1:0]  vec_buf_q, vec_buf_d;
    logic               vec_done_q, vec_done_d;
    logic               wrong_q, wrong_d;
    logic [CAUSE_W-1:0] cause_q, cause_d, cause_now;
    logic [CNT_W-1:0]   pres_mis_q, pres_mis_d, count_mis_q, count_mis_d;
    logic [CNT_W-1:0]   vec_mis_q, vec_mis_d, checked_q, checked_d, ffi_q, ffi_d;
    logic [ES-1:0]      push_pop;
    logic [DATA_W-1:0]  beat_ext;
    logic [AW-1:0]      wp_inc, lvl_diff;
    logic               full, push_acc;

    bch_scoreboard_popcount #(.DATA_W(DATA_W), .ES(ES)) u_popcount (
        .data  (push_err),
        .count (push_pop)
    );

    // A slot held by any of the three readers blocks the writer, so a check
    // retiring in this cycle cannot make room for a push in the same cycle.
    assign wp_inc   = wp_q + AW'(1);
    assign full     = (wp_inc == rp_pres_q) || (wp_inc == rp_cnt_q) || (wp_inc == rp_vec_q);
    assign lvl_diff = wp_q - rp_vec_q;
    assign beat_ext = DATA_W'(err) << (DATA_W - BITS);

    always_comb begin
        wp_d        = wp_q;
        rp_pres_d   = rp_pres_q;
        rp_cnt_d    = rp_cnt_q;
        rp_vec_d    = rp_vec_q;
        vec_buf_d   = vec_buf_q;
        vec_done_d  = err_valid && err_last;
        pres_mis_d  = pres_mis_q;
        count_mis_d = count_mis_q;
        vec_mis_d   = vec_mis_q;
        checked_d   = checked_q;
        ffi_d       = ffi_q;
        cause_now   = '0;
        push_acc    = 1'b0;

        if (err_valid) begin
            vec_buf_d = err_first ? beat_ext : (beat_ext | (vec_buf_q >> BITS));
        end

        if (pres_valid) begin
            if (rp_pres_q == wp_q) begin
                cause_now[CAUSE_UNF] = 1'b1;
            end else begin
                if (pres_actual != any_mem[rp_pres_q]) begin
                    cause_now[CAUSE_PRES] = 1'b1;
                    pres_mis_d            = sat_inc(pres_mis_q);
                end
                rp_pres_d = rp_pres_q + AW'(1);
            end
        end

        if (count_valid) begin
            if (rp_cnt_q == wp_q) begin
                cause_now[CAUSE_UNF] = 1'b1;
            end else begin
                if (count_actual != pop_mem[rp_cnt_q]) begin
                    cause_now[CAUSE_CNT] = 1'b1;
                    count_mis_d          = sat_inc(count_mis_q);
                end
                rp_cnt_d = rp_cnt_q + AW'(1);
            end
        end

        if (vec_done_q) begin
            if (rp_vec_q == wp_q) begin
                cause_now[CAUSE_UNF] = 1'b1;
            end else begin
                if (vec_buf_q != pat_mem[rp_vec_q]) begin
                    cause_now[CAUSE_VEC] = 1'b1;
                    vec_mis_d            = sat_inc(vec_mis_q);
                end
                rp_vec_d  = rp_vec_q + AW'(1);
                checked_d = sat_inc(checked_q);
            end
        end

        if (push) begin
            if (full) begin
                cause_now[CAUSE_OVF] = 1'b1;
            end else begin
                push_acc = 1'b1;
                wp_d     = wp_inc;
            end
        end

        // Index snapshot uses the pre-increment count of this cycle.
        if (!wrong_q && (|cause_now)) begin
            ffi_d = checked_q;
        end
        cause_d = cause_q | cause_now;
        wrong_d = wrong_q | (|cause_now);

        if (clear) begin
            wp_d        = '0;
            rp_pres_d   = '0;
            rp_cnt_d    = '0;
            rp_vec_d    = '0;
            vec_buf_d   = '0;
            vec_done_d  = 1'b0;
            pres_mis_d  = '0;
            count_mis_d = '0;
            vec_mis_d   = '0;
            checked_d   = '0;
            ffi_d       = '0;
            cause_d     = '0;
            wrong_d     = 1'b0;
            push_acc    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            pat_mem[wp_q] <= push_err;
            pop_mem[wp_q] <= push_pop;
            any_mem[wp_q] <= |push_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q        <= '0;
            rp_pres_q   <= '0;
            rp_cnt_q    <= '0;
            rp_vec_q    <= '0;
            vec_buf_q   <= '0;
            vec_done_q  <= 1'b0;
            pres_mis_q  <= '0;
            count_mis_q <= '0;
            vec_mis_q   <= '0;
            checked_q   <= '0;
            ffi_q       <= '0;
            cause_q     <= '0;
            wrong_q     <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_pres_q   <= rp_pres_d;
            rp_cnt_q    <= rp_cnt_d;
            rp_vec_q    <= rp_vec_d;
            vec_buf_q   <= vec_buf_d;
            vec_done_q  <= vec_done_d;
            pres_mis_q  <= pres_mis_d;
            count_mis_q <= count_mis_d;
            vec_mis_q   <= vec_mis_d;
            checked_q   <= checked_d;
            ffi_q       <= ffi_d;
            cause_q     <= cause_d;
            wrong_q     <= wrong_d;
        end
    end

    assign push_ready     = !full;
    assign wrong          = wrong_q;
    assign fail_cause     = cause_q;
    assign pres_mis       = pres_mis_q;
    assign count_mis      = count_mis_q;
    assign vec_mis        = vec_mis_q;
    assign checked        = checked_q;
    assign first_fail_idx = ffi_q;
    assign level          = {1'b0, lvl_diff};

endmodule

// File: tb/tb_bch_scoreboard.sv
// Self-checking bench for bch_scoreboard: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_bch_scoreboard;
    import bch_scoreboard_pkg::*;

    localparam int DW    = 8;
    localparam int BITS  = 1;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int ES    = log2c(DW + 1);
    localparam int AW    = log2c(DEPTH);
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset, clear, push, pres_valid, pres_actual, count_valid;
    logic err_valid, err_first, err_last;
    logic [DW-1:0]    push_err;
    logic [ES-1:0]    count_actual;
    logic [BITS-1:0]  err;
    logic             push_ready, wrong;
    logic [4:0]       fail_cause;
    logic [CNT_W-1:0] pres_mis, count_mis, vec_mis, checked, first_fail_idx;
    logic [AW:0]      level;

    // second instance: whole vector in one beat
    logic b_clear, b_push, b_pres_valid, b_pres_actual, b_count_valid;
    logic b_err_valid, b_err_first, b_err_last;
    logic [DW-1:0]    b_push_err, b_err;
    logic [ES-1:0]    b_count_actual;
    logic             b_push_ready, b_wrong;
    logic [4:0]       b_fail_cause;
    logic [CNT_W-1:0] b_pres_mis, b_count_mis, b_vec_mis, b_checked, b_ffi;
    logic [AW:0]      b_level;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    bch_scoreboard #(.DATA_W(DW), .BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .push_err(push_err),
        .push_ready(push_ready), .pres_valid(pres_valid), .pres_actual(pres_actual),
        .count_valid(count_valid), .count_actual(count_actual), .err_valid(err_valid),
        .err_first(err_first), .err_last(err_last), .err(err), .wrong(wrong),
        .fail_cause(fail_cause), .pres_mis(pres_mis), .count_mis(count_mis),
        .vec_mis(vec_mis), .checked(checked), .first_fail_idx(first_fail_idx), .level(level)
    );

    bch_scoreboard #(.DATA_W(DW), .BITS(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .reset(reset), .clear(b_clear), .push(b_push), .push_err(b_push_err),
        .push_ready(b_push_ready), .pres_valid(b_pres_valid), .pres_actual(b_pres_actual),
        .count_valid(b_count_valid), .count_actual(b_count_actual), .err_valid(b_err_valid),
        .err_first(b_err_first), .err_last(b_err_last), .err(b_err), .wrong(b_wrong),
        .fail_cause(b_fail_cause), .pres_mis(b_pres_mis), .count_mis(b_count_mis),
        .vec_mis(b_vec_mis), .checked(b_checked), .first_fail_idx(b_ffi), .level(b_level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: absolute entry counts instead of wrapped pointers.
    logic [DW-1:0] hist[$];
    int m_push_n, m_pres_n, m_cnt_n, m_vec_n;
    int m_pres_mis, m_cnt_mis, m_vec_mis, m_checked, m_ffi, m_vidx;
    logic [4:0] m_cause;
    bit m_wrong, m_vpend;
    logic [DW-1:0] m_vacc, m_vdone_val;

    function automatic bit m_full();
        return (m_push_n - m_pres_n == DEPTH - 1) || (m_push_n - m_cnt_n == DEPTH - 1) ||
               (m_push_n - m_vec_n == DEPTH - 1);
    endfunction

    task automatic m_zero();
        hist.delete();
        m_push_n = 0; m_pres_n = 0; m_cnt_n = 0; m_vec_n = 0;
        m_pres_mis = 0; m_cnt_mis = 0; m_vec_mis = 0; m_checked = 0; m_ffi = 0;
        m_vidx = 0; m_cause = '0; m_wrong = 0; m_vpend = 0; m_vacc = '0; m_vdone_val = '0;
    endtask

    task automatic m_step();
        logic [4:0] now;
        bit full;
        int old_checked;
        now = '0;
        full = m_full();
        old_checked = m_checked;
        if (pres_valid) begin
            if (m_pres_n == m_push_n) now[CAUSE_UNF] = 1'b1;
            else begin
                if (pres_actual != (hist[m_pres_n] != 0)) begin
                    now[CAUSE_PRES] = 1'b1;
                    if (m_pres_mis < SAT) m_pres_mis++;
                end
                m_pres_n++;
            end
        end
        if (count_valid) begin
            if (m_cnt_n == m_push_n) now[CAUSE_UNF] = 1'b1;
            else begin
                if (int'(count_actual) != $countones(hist[m_cnt_n])) begin
                    now[CAUSE_CNT] = 1'b1;
                    if (m_cnt_mis < SAT) m_cnt_mis++;
                end
                m_cnt_n++;
            end
        end
        if (m_vpend) begin
            if (m_vec_n == m_push_n) now[CAUSE_UNF] = 1'b1;
            else begin
                if (m_vdone_val != hist[m_vec_n]) begin
                    now[CAUSE_VEC] = 1'b1;
                    if (m_vec_mis < SAT) m_vec_mis++;
                end
                m_vec_n++;
                if (m_checked < SAT) m_checked++;
            end
        end
        if (push) begin
            if (full) now[CAUSE_OVF] = 1'b1;
            else begin
                hist.push_back(push_err);
                m_push_n++;
            end
        end
        m_vpend = err_valid && err_last;
        if (err_valid) begin
            if (err_first) begin
                m_vacc = DW'(err);
                m_vidx = 1;
            end else begin
                m_vacc = m_vacc | (DW'(err) << (m_vidx * BITS));
                m_vidx++;
            end
            if (err_last) m_vdone_val = m_vacc;
        end
        if (now != 0 && !m_wrong) begin
            m_wrong = 1;
            m_ffi   = old_checked;
        end
        m_cause = m_cause | now;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset || clear) m_zero();
        else m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wrong", wrong, m_wrong);
            chk("fail_cause", fail_cause, m_cause);
            chk("pres_mis", pres_mis, m_pres_mis);
            chk("count_mis", count_mis, m_cnt_mis);
            chk("vec_mis", vec_mis, m_vec_mis);
            chk("checked", checked, m_checked);
            chk("first_fail_idx", first_fail_idx, m_ffi);
            chk("level", level, m_push_n - m_vec_n);
            chk("push_ready", push_ready, !m_full());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; push = 0; pres_valid = 0; pres_actual = 0; count_valid = 0;
        count_actual = '0; err_valid = 0; err_first = 0; err_last = 0; err = '0;
    endtask

    task automatic do_push(input logic [DW-1:0] p);
        push = 1; push_err = p;
        cyc();
        push = 0;
    endtask

    task automatic send_vec(input logic [DW-1:0] p);
        for (int i = 0; i < DW; i++) begin
            err_valid = 1; err = p[i]; err_first = (i == 0); err_last = (i == DW - 1);
            cyc();
        end
        err_valid = 0; err_first = 0; err_last = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        cyc();
        clear = 0;
    endtask

    initial begin
        logic [DW-1:0] pats [3];
        logic [DW-1:0] p, vpat;
        int vb;
        pats[0] = 8'h00; pats[1] = 8'h21; pats[2] = 8'h04;
        idle();
        push_err = '0;
        b_clear = 0; b_push = 0; b_push_err = '0; b_pres_valid = 0; b_pres_actual = 0;
        b_count_valid = 0; b_count_actual = '0; b_err_valid = 0; b_err_first = 0;
        b_err_last = 0; b_err = '0;
        reset = 1;
        cyc(); cyc();
        reset = 0;
        chk_en = 1;
        cyc();
        chk("rst_push_ready", push_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_wrong", wrong, 0);
        chk("rst_cause", fail_cause, 0);

        // three matching entries through all three check points
        for (int i = 0; i < 3; i++) do_push(pats[i]);
        for (int i = 0; i < 3; i++) begin
            pres_valid = 1; pres_actual = (pats[i] != 0);
            count_valid = 1; count_actual = ES'($countones(pats[i]));
            cyc();
        end
        pres_valid = 0; count_valid = 0;
        for (int i = 0; i < 3; i++) begin
            send_vec(pats[i]);
            cyc();
        end
        chk("match_wrong", wrong, 0);
        chk("match_checked", checked, 3);
        chk("match_level", level, 0);
        chk("model_checked", m_checked, 3);

        // single-beat vector with one flipped bit, reported two cycles later
        b_push = 1; b_push_err = 8'h5A;
        cyc();
        b_push = 0;
        b_err_valid = 1; b_err_first = 1; b_err_last = 1; b_err = 8'h5A ^ 8'h08;
        cyc();
        b_err_valid = 0; b_err_first = 0; b_err_last = 0;
        chk("b_vec_mis_early", b_vec_mis, 0);
        chk("b_cause_early", b_fail_cause, 0);
        cyc();
        chk("b_vec_mis", b_vec_mis, 1);
        chk("b_cause", b_fail_cause, 5'b00100);
        chk("b_checked", b_checked, 1);
        chk("b_wrong", b_wrong, 1);

        // count mismatch
        do_clear();
        do_push(8'h21);
        count_valid = 1; count_actual = 1;
        cyc();
        count_valid = 0;
        chk("cnt_cause", fail_cause, 5'b00010);
        chk("cnt_mis", count_mis, 1);
        chk("cnt_wrong", wrong, 1);
        chk("cnt_ffi", first_fail_idx, 0);

        // overflow
        do_clear();
        for (int i = 0; i < 4; i++) begin
            do_push(DW'(i + 1));
            if (i == 2) chk("ovf_ready_low", push_ready, 0);
        end
        chk("ovf_cause", fail_cause, 5'b01000);
        chk("ovf_level", level, 3);

        // underflow leaves the read pointer in place
        do_clear();
        pres_valid = 1; pres_actual = 1;
        cyc();
        pres_valid = 0;
        chk("unf_cause", fail_cause, 5'b10000);
        chk("unf_pres_mis", pres_mis, 0);
        do_push(8'h10);
        pres_valid = 1; pres_actual = 0;
        cyc();
        pres_valid = 0;
        chk("unf_held_ptr", pres_mis, 1);

        // counter saturation, then an all-at-once clear
        do_clear();
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            p = DW'($urandom_range(1, 255));
            do_push(p);
            count_valid = 1; count_actual = ES'($countones(p) + 1);
            pres_valid = 1; pres_actual = 1;
            cyc();
            count_valid = 0; pres_valid = 0;
            send_vec(p);
            cyc();
        end
        chk("sat_count_mis", count_mis, 15);
        chk("sat_model", m_cnt_mis, 15);
        chk("sat_checked", checked, 15);
        chk("sat_vec_mis", vec_mis, 0);
        do_clear();
        chk("clr_wrong", wrong, 0);
        chk("clr_cause", fail_cause, 0);
        chk("clr_count_mis", count_mis, 0);
        chk("clr_checked", checked, 0);
        chk("clr_ready", push_ready, 1);

        // reset in the middle of a vector
        do_push(8'h3C);
        for (int i = 0; i < 3; i++) begin
            err_valid = 1; err = 1'b1; err_first = (i == 0); err_last = 0;
            cyc();
        end
        idle();
        reset = 1;
        cyc();
        reset = 0;
        do_push(8'h3C);
        send_vec(8'h3C);
        cyc();
        chk("rstmid_vec_mis", vec_mis, 0);
        chk("rstmid_checked", checked, 1);

        // random traffic
        do_clear();
        vb = -1;
        vpat = '0;
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 199) == 0) begin
                clear = 1;
                vb = -1;
            end else begin
                push = ($urandom_range(0, 2) == 0);
                push_err = DW'($urandom) & DW'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    pres_valid = 1;
                    pres_actual = (m_pres_n < m_push_n) ? (hist[m_pres_n] != 0) : 1'($urandom);
                    if ($urandom_range(0, 9) == 0) pres_actual = !pres_actual;
                end
                if ($urandom_range(0, 2) == 0) begin
                    count_valid = 1;
                    count_actual = (m_cnt_n < m_push_n) ? ES'($countones(hist[m_cnt_n])) : ES'($urandom);
                    if ($urandom_range(0, 9) == 0) count_actual = count_actual + ES'($urandom_range(1, 3));
                end
                if (vb < 0 && !m_vpend && $urandom_range(0, 3) == 0) begin
                    vpat = (m_vec_n < m_push_n) ? hist[m_vec_n] : DW'($urandom);
                    if ($urandom_range(0, 7) == 0) vpat = vpat ^ (DW'(1) << $urandom_range(0, DW - 1));
                    vb = 0;
                end
                if (vb >= 0) begin
                    err_valid = 1; err = vpat[vb]; err_first = (vb == 0); err_last = (vb == DW - 1);
                    vb = (vb == DW - 1) ? -1 : vb + 1;
                end
            end
            cyc();
        end
        idle();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
